seven_segment_reader: RTL and testbench

- Receive side of the multiplexed seven-segment display bus: samples time-multiplexed segment lines plus digit enables and recovers the displayed hex nibble for each digit.
- Each segment pattern must be stable for a programmable number of samples before it is accepted.
- Once every digit has been captured, the complete frame is presented on a valid/ready output.
- Used in loopback self-test of the multiplier display path and for sniffing external display boards.

---
 rtl/seven_segment_pkg.sv | 55 +++++
 rtl/seven_segment_pattern_decoder.sv | 42 ++++
 rtl/seven_segment_reader.sv | 214 +++++++++++++++++++++
 tb/tb_seven_segment_reader.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/seven_segment_pkg.sv
// ============================================================================
// Module : seven_segment_pkg
// Brief  : Segment pattern constants, bit order and decode/FSM types shared by
//          the seven-segment display reader.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package seven_segment_pkg;

    localparam int SEG_W     = 7;
    localparam int SEG_A_BIT = 0;
    localparam int SEG_B_BIT = 1;
    localparam int SEG_C_BIT = 2;
    localparam int SEG_D_BIT = 3;
    localparam int SEG_E_BIT = 4;
    localparam int SEG_F_BIT = 5;
    localparam int SEG_G_BIT = 6;

    // Active-high gfedcba patterns for each hex glyph.
    localparam logic [SEG_W-1:0] SEG_0 = 7'h3F;
    localparam logic [SEG_W-1:0] SEG_1 = 7'h06;
    localparam logic [SEG_W-1:0] SEG_2 = 7'h5B;
    localparam logic [SEG_W-1:0] SEG_3 = 7'h4F;
    localparam logic [SEG_W-1:0] SEG_4 = 7'h66;
    localparam logic [SEG_W-1:0] SEG_5 = 7'h6D;
    localparam logic [SEG_W-1:0] SEG_6 = 7'h7D;
    localparam logic [SEG_W-1:0] SEG_7 = 7'h07;
    localparam logic [SEG_W-1:0] SEG_8 = 7'((1 << SEG_A_BIT) | (1 << SEG_B_BIT) |
                                            (1 << SEG_C_BIT) | (1 << SEG_D_BIT) |
                                            (1 << SEG_E_BIT) | (1 << SEG_F_BIT) |
                                            (1 << SEG_G_BIT));
    localparam logic [SEG_W-1:0] SEG_9 = 7'h6F;
    localparam logic [SEG_W-1:0] SEG_A = 7'h77;
    localparam logic [SEG_W-1:0] SEG_B = 7'h7C;
    localparam logic [SEG_W-1:0] SEG_C = 7'h39;
    localparam logic [SEG_W-1:0] SEG_D = 7'h5E;
    localparam logic [SEG_W-1:0] SEG_E = 7'h79;
    localparam logic [SEG_W-1:0] SEG_F = 7'h71;
    localparam logic [SEG_W-1:0] SEG_BLANK = 7'h00;

    typedef struct packed {
        logic [3:0] nibble;
        logic       blank;
        logic       error;
    } decode_t;

    typedef enum logic [0:0] {
        ST_COLLECT = 1'b0,
        ST_PENDING = 1'b1
    } frame_state_e;

endpackage

`default_nettype wire

// File: rtl/seven_segment_pattern_decoder.sv
// ============================================================================
// Module : seven_segment_pattern_decoder
// Brief  : Combinational active-high gfedcba pattern to hex nibble decoder
//          with blank and unrecognised-pattern flags.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module seven_segment_pattern_decoder
    import seven_segment_pkg::*;
(
    input  logic [SEG_W-1:0] pattern,
    output decode_t          result
);

    always_comb begin
        result = '0;
        case (pattern)
            SEG_0:     result.nibble = 4'h0;
            SEG_1:     result.nibble = 4'h1;
            SEG_2:     result.nibble = 4'h2;
            SEG_3:     result.nibble = 4'h3;
            SEG_4:     result.nibble = 4'h4;
            SEG_5:     result.nibble = 4'h5;
            SEG_6:     result.nibble = 4'h6;
            SEG_7:     result.nibble = 4'h7;
            SEG_8:     result.nibble = 4'h8;
            SEG_9:     result.nibble = 4'h9;
            SEG_A:     result.nibble = 4'hA;
            SEG_B:     result.nibble = 4'hB;
            SEG_C:     result.nibble = 4'hC;
            SEG_D:     result.nibble = 4'hD;
            SEG_E:     result.nibble = 4'hE;
            SEG_F:     result.nibble = 4'hF;
            SEG_BLANK: result.blank  = 1'b1;
            default:   result.error  = 1'b1;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/seven_segment_reader.sv
// ============================================================================
// Module : seven_segment_reader
// Brief  : Recovers hex digits from a multiplexed seven-segment bus, debounces
//          each digit and delivers complete frames on a valid/ready output.
// Macro  : SEVEN_SEGMENT_READER_CHANGE_ONLY_EN - drop frames identical to the
//          last delivered one.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module seven_segment_reader
    import seven_segment_pkg::*;
#(
    parameter int NUM_DIGITS    = 4,
    parameter int STABLE_CYCLES = 4,
    parameter bit COMMON_ANODE  = 1'b1
) (
    input  logic                    i_clk,
    input  logic                    i_rst_n,
    input  logic [SEG_W-1:0]        i_segments,
    input  logic [NUM_DIGITS-1:0]   i_digit_en,
    input  logic                    i_ready,
    output logic                    o_valid,
    output logic [4*NUM_DIGITS-1:0] o_value,
    output logic [NUM_DIGITS-1:0]   o_blank,
    output logic [NUM_DIGITS-1:0]   o_error
);

    localparam int               CNT_W    = 8;
    localparam logic [CNT_W-1:0] C_STABLE = CNT_W'(STABLE_CYCLES);

    logic [SEG_W-1:0]        r_seg;
    logic [SEG_W-1:0]        r_seg_prev;
    logic [NUM_DIGITS-1:0]   r_en;
    logic [NUM_DIGITS-1:0]   r_en_prev;
    logic [CNT_W-1:0]        r_cnt;
    logic [CNT_W-1:0]        w_cnt_next;
    logic                    w_onehot;
    logic                    w_same;
    logic                    w_accept;
    logic [NUM_DIGITS-1:0]   w_accept_mask;
    decode_t                 w_dec;

    logic [NUM_DIGITS-1:0]   r_seen;
    logic                    w_all_seen;
    logic [4*NUM_DIGITS-1:0] r_shadow_value;
    logic [NUM_DIGITS-1:0]   r_shadow_blank;
    logic [NUM_DIGITS-1:0]   r_shadow_error;

    frame_state_e            r_state;
    frame_state_e            w_state_next;
    logic                    w_slot_free;
    logic                    w_load;
    logic                    w_discard;
    logic                    w_dup;

    logic                    r_valid;
    logic [4*NUM_DIGITS-1:0] r_value;
    logic [NUM_DIGITS-1:0]   r_blank;
    logic [NUM_DIGITS-1:0]   r_error;

    // Sample stage plus one-cycle history for the stability comparison.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_seg      <= '0;
            r_en       <= '0;
            r_seg_prev <= '0;
            r_en_prev  <= '0;
        end else begin
            r_seg      <= COMMON_ANODE ? ~i_segments : i_segments;
            r_en       <= i_digit_en;
            r_seg_prev <= r_seg;
            r_en_prev  <= r_en;
        end
    end

    assign w_onehot = $onehot(r_en);
    assign w_same   = (r_seg == r_seg_prev) && (r_en == r_en_prev);

    always_comb begin
        w_cnt_next = r_cnt;
        if (!w_onehot) begin
            w_cnt_next = '0;
        end else if (!w_same) begin
            w_cnt_next = CNT_W'(1);
        end else if (r_cnt != C_STABLE) begin
            w_cnt_next = r_cnt + CNT_W'(1);
        end
    end

    // Accept only on the transition into saturation so a held digit is written once.
    assign w_accept      = w_onehot && (w_cnt_next == C_STABLE) && (r_cnt != C_STABLE);
    assign w_accept_mask = w_accept ? r_en : '0;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= w_cnt_next;
        end
    end

    seven_segment_pattern_decoder u_decoder (
        .pattern (r_seg),
        .result  (w_dec)
    );

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_shadow_value <= '0;
            r_shadow_blank <= '0;
            r_shadow_error <= '0;
        end else begin
            for (int k = 0; k < NUM_DIGITS; k++) begin
                if (w_accept_mask[k]) begin
                    r_shadow_value[4*k +: 4] <= w_dec.nibble;
                    r_shadow_blank[k]        <= w_dec.blank;
                    r_shadow_error[k]        <= w_dec.error;
                end
            end
        end
    end

    assign w_all_seen  = &r_seen;
    assign w_slot_free = !r_valid || i_ready;

`ifdef SEVEN_SEGMENT_READER_CHANGE_ONLY_EN
    logic [6*NUM_DIGITS-1:0] r_last_frame;
    logic                    r_have_last;

    assign w_dup = r_have_last &&
                   ({r_shadow_value, r_shadow_blank, r_shadow_error} == r_last_frame);

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_last_frame <= '0;
            r_have_last  <= 1'b0;
        end else if (w_load) begin
            r_last_frame <= {r_shadow_value, r_shadow_blank, r_shadow_error};
            r_have_last  <= 1'b1;
        end
    end
`else
    assign w_dup = 1'b0;
`endif

    always_comb begin
        w_state_next = r_state;
        w_load       = 1'b0;
        w_discard    = 1'b0;
        case (r_state)
            ST_COLLECT: begin
                if (w_all_seen) begin
                    if (w_dup) begin
                        w_discard = 1'b1;
                    end else if (w_slot_free) begin
                        w_load = 1'b1;
                    end else begin
                        w_state_next = ST_PENDING;
                    end
                end
            end
            ST_PENDING: begin
                if (w_dup) begin
                    w_discard    = 1'b1;
                    w_state_next = ST_COLLECT;
                end else if (w_slot_free) begin
                    w_load       = 1'b1;
                    w_state_next = ST_COLLECT;
                end
            end
            default: w_state_next = ST_COLLECT;
        endcase
    end

    // A digit accepted in the same cycle a frame is consumed counts toward the next frame.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state <= ST_COLLECT;
            r_seen  <= '0;
        end else begin
            r_state <= w_state_next;
            if (w_load || w_discard) begin
                r_seen <= w_accept_mask;
            end else begin
                r_seen <= r_seen | w_accept_mask;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_valid <= 1'b0;
            r_value <= '0;
            r_blank <= '0;
            r_error <= '0;
        end else if (w_load) begin
            r_valid <= 1'b1;
            r_value <= r_shadow_value;
            r_blank <= r_shadow_blank;
            r_error <= r_shadow_error;
        end else if (r_valid && i_ready) begin
            r_valid <= 1'b0;
        end
    end

    assign o_valid = r_valid;
    assign o_value = r_value;
    assign o_blank = r_blank;
    assign o_error = r_error;

endmodule

`default_nettype wire

// File: tb/tb_seven_segment_reader.sv
// ============================================================================
// Module : tb_seven_segment_reader
// Brief  : Directed self-checking bench for seven_segment_reader (4 digits,
//          4-sample debounce, common-anode segment lines).
// Rev    : 1.0
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_seven_segment_reader;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [6:0]  segments = 7'h7F;
    logic [3:0]  digit_en = 4'b0000;
    logic        ready = 1'b1;
    logic        valid;
    logic [15:0] value;
    logic [3:0]  blank;
    logic [3:0]  error;

    int vectors = 0;
    int miscompares = 0;
    int valid_cycles = 0;
    logic [23:0] frames[$];

    always #5 clk = ~clk;

    seven_segment_reader #(
        .NUM_DIGITS    (4),
        .STABLE_CYCLES (4),
        .COMMON_ANODE  (1'b1)
    ) dut (
        .i_clk      (clk),
        .i_rst_n    (rst_n),
        .i_segments (segments),
        .i_digit_en (digit_en),
        .i_ready    (ready),
        .o_valid    (valid),
        .o_value    (value),
        .o_blank    (blank),
        .o_error    (error)
    );

    // Frames are recorded at the handshake, sampled mid-cycle.
    always @(negedge clk) begin
        if (rst_n) begin
            if (valid) valid_cycles++;
            if (valid && ready) frames.push_back({value, blank, error});
        end
    end

    task automatic check_vec(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic show(input int d, input logic [6:0] pat, input int n);
        digit_en = 4'(1 << d);
        segments = ~pat;
        tick(n);
    endtask

    task automatic idle(input int n);
        digit_en = 4'b0000;
        segments = 7'h7F;
        tick(n);
    endtask

    task automatic send_frame(input logic [6:0] p0, input logic [6:0] p1,
                              input logic [6:0] p2, input logic [6:0] p3);
        show(0, p0, 6);
        show(1, p1, 6);
        show(2, p2, 6);
        show(3, p3, 6);
        idle(6);
    endtask

    function automatic logic [31:0] frame_at(input int idx);
        if (idx < frames.size()) return {8'h00, frames[idx]};
        return 32'hFFFF_FFFF;
    endfunction

    initial begin
        int exp_frames;

        rst_n = 1'b0;
        tick(3);
        check_vec("rst_valid", {31'd0, valid}, 32'd0);
        check_vec("rst_value", {16'd0, value}, 32'd0);
        check_vec("rst_blank", {28'd0, blank}, 32'd0);
        check_vec("rst_error", {28'd0, error}, 32'd0);
        rst_n = 1'b1;
        idle(2);

        // Basic frame 3210
        frames.delete();
        valid_cycles = 0;
        ready = 1'b1;
        send_frame(7'h3F, 7'h06, 7'h5B, 7'h4F);
        check_vec("t1_count", frames.size(), 1);
        check_vec("t1_frame", frame_at(0), {8'h00, 16'h3210, 4'b0000, 4'b0000});
        check_vec("t1_valid_cycles", valid_cycles, 1);

        // Short glitches are never accepted
        frames.delete();
        show(2, 7'h5B, 3);
        show(2, 7'h66, 6);
        show(0, 7'h3F, 6);
        show(1, 7'h06, 6);
        show(2, 7'h7F, 3);
        show(3, 7'h4F, 6);
        idle(6);
        check_vec("t2_count", frames.size(), 1);
        check_vec("t2_frame", frame_at(0), {8'h00, 16'h3410, 4'b0000, 4'b0000});

        // Blank and unrecognised digits
        frames.delete();
        send_frame(7'h3F, 7'h00, 7'h5B, 7'h49);
        check_vec("t3_count", frames.size(), 1);
        check_vec("t3_frame", frame_at(0), {8'h00, 16'h0200, 4'b0010, 4'b1000});

        // Back-pressure: two frames complete while ready is low
        frames.delete();
        ready = 1'b0;
        send_frame(7'h66, 7'h4F, 7'h5B, 7'h06);
        send_frame(7'h7F, 7'h07, 7'h7D, 7'h6D);
        check_vec("t4_hold_valid", {31'd0, valid}, 32'd1);
        check_vec("t4_hold_value", {16'd0, value}, 32'h1234);
        check_vec("t4_no_handshake", frames.size(), 0);
        ready = 1'b1;
        tick(1);
        ready = 1'b0;
        check_vec("t4_b2b_valid", {31'd0, valid}, 32'd1);
        check_vec("t4_b2b_value", {16'd0, value}, 32'h5678);
        tick(3);
        check_vec("t4_hold2_value", {16'd0, value}, 32'h5678);
        ready = 1'b1;
        tick(2);
        check_vec("t4_valid_drop", {31'd0, valid}, 32'd0);
        check_vec("t4_first", frame_at(0), {8'h00, 16'h1234, 8'h00});
        check_vec("t4_second", frame_at(1), {8'h00, 16'h5678, 8'h00});

        // Non-one-hot enables, then reset mid-frame discards partial collection
        frames.delete();
        show(0, 7'h6F, 6);
        show(1, 7'h77, 6);
        show(2, 7'h7C, 6);
        digit_en = 4'b0011;
        segments = ~7'h3F;
        tick(10);
        check_vec("t5_no_frame_multi", frames.size(), 0);
        rst_n = 1'b0;
        tick(2);
        check_vec("t5_rst_valid", {31'd0, valid}, 32'd0);
        check_vec("t5_rst_value", {16'd0, value}, 32'd0);
        check_vec("t5_rst_blank", {28'd0, blank}, 32'd0);
        check_vec("t5_rst_error", {28'd0, error}, 32'd0);
        rst_n = 1'b1;
        show(3, 7'h39, 6);
        idle(6);
        check_vec("t5_partial_valid", {31'd0, valid}, 32'd0);
        check_vec("t5_partial_count", frames.size(), 0);
        show(0, 7'h6F, 6);
        show(1, 7'h77, 6);
        show(2, 7'h7C, 6);
        idle(6);
        check_vec("t5_count", frames.size(), 1);
        check_vec("t5_frame", frame_at(0), {8'h00, 16'hCBA9, 8'h00});

        // Repeated frames, then a changed one
        frames.delete();
        repeat (3) send_frame(7'h5E, 7'h39, 7'h7C, 7'h77);
        send_frame(7'h79, 7'h39, 7'h7C, 7'h77);
`ifdef SEVEN_SEGMENT_READER_CHANGE_ONLY_EN
        exp_frames = 2;
`else
        exp_frames = 4;
`endif
        check_vec("t6_count", frames.size(), exp_frames);
        check_vec("t6_first", frame_at(0), {8'h00, 16'hABCD, 8'h00});
        check_vec("t6_last", frame_at(exp_frames - 1), {8'h00, 16'hABCE, 8'h00});

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

`default_nettype wire
